// File: rtl/vend_ctrl_if.sv
// Coin/button inputs and dispenser/status outputs of the vending controller.
// The master side drives coins and requests; the slave side is the controller.
interface vend_ctrl_if #(
  parameter int unsigned CREDIT_W = 4,
  parameter int unsigned NUM_PROD = 3,
  parameter int unsigned SEL_W    = 2
) ();
  logic                c05;
  logic                c10;
  logic [SEL_W-1:0]    sel;
  logic                cancel;
  logic [NUM_PROD-1:0] dispense;
  logic                change_05;
  logic                coin_rej;
  logic [CREDIT_W-1:0] credit;
  logic                busy;
  logic [2:0]          state;

  modport master (
    output c05, c10, sel, cancel,
    input  dispense, change_05, coin_rej, credit, busy, state
  );

  modport slave (
    input  c05, c10, sel, cancel,
    output dispense, change_05, coin_rej, credit, busy, state
  );
endinterface

// File: rtl/vend_ctrl.sv
// Vending controller: accumulates nickel/dime credit, serves one of NUM_PROD priced
// products, and pays back remaining credit as one nickel pulse per cycle.
module vend_ctrl #(
  parameter int unsigned                    CREDIT_W     = 4,
  parameter int unsigned                    NUM_PROD     = 3,
  parameter int unsigned                    SEL_W        = 2,
  parameter logic [NUM_PROD*CREDIT_W-1:0]   PRICE_LIST   = {4'd6, 4'd5, 4'd4},
  parameter int unsigned                    MAX_CREDIT   = 15,
  parameter int unsigned                    DISPENSE_CYC = 2
) (
  input logic        clock,
  input logic        reset,
  vend_ctrl_if.slave vend
);

  localparam logic [2:0] StIdle     = 3'd0;
  localparam logic [2:0] StCollect  = 3'd1;
  localparam logic [2:0] StReady    = 3'd2;
  localparam logic [2:0] StDispense = 3'd3;
  localparam logic [2:0] StChange   = 3'd4;

  localparam int unsigned        CntW    = (DISPENSE_CYC > 1) ? $clog2(DISPENSE_CYC) : 1;
  localparam logic [CntW-1:0]    CntInit = CntW'(DISPENSE_CYC - 1);
  localparam logic [CREDIT_W:0]  MaxSum  = (CREDIT_W + 1)'(MAX_CREDIT);

  logic [2:0]          state_q, state_d;
  logic [CREDIT_W-1:0] credit_q, credit_d;
  logic [NUM_PROD-1:0] dispense_q, dispense_d;
  logic                change_q, change_d;
  logic                rej_q, rej_d;
  logic [CntW-1:0]     cnt_q, cnt_d;

  logic [1:0]          coin_v;
  logic                coin_any;
  logic [CREDIT_W:0]   sum;
  logic [CREDIT_W-1:0] min_price;
  logic [CREDIT_W-1:0] sel_price;
  logic [NUM_PROD-1:0] sel_onehot;
  logic                sel_ok;

  assign coin_v   = {vend.c10, vend.c05};
  assign coin_any = vend.c05 | vend.c10;
  // One bit wider than credit so an overflowing deposit is detected, not wrapped.
  assign sum      = (CREDIT_W + 1)'(credit_q) + (CREDIT_W + 1)'(coin_v);

  always_comb begin
    min_price  = PRICE_LIST[CREDIT_W-1:0];
    sel_price  = '0;
    sel_onehot = '0;
    sel_ok     = 1'b0;
    for (int k = 0; k < NUM_PROD; k++) begin
      if (PRICE_LIST[k*CREDIT_W +: CREDIT_W] < min_price) begin
        min_price = PRICE_LIST[k*CREDIT_W +: CREDIT_W];
      end
      if (int'(vend.sel) == k + 1) begin
        sel_ok        = 1'b1;
        sel_price     = PRICE_LIST[k*CREDIT_W +: CREDIT_W];
        sel_onehot[k] = 1'b1;
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    credit_d   = credit_q;
    dispense_d = dispense_q;
    cnt_d      = cnt_q;
    change_d   = 1'b0;
    rej_d      = 1'b0;
    case (state_q)
      StIdle, StCollect, StReady: begin
        if (vend.cancel && (state_q != StIdle)) begin
          state_d = StChange;
          rej_d   = coin_any;
        end else if ((state_q == StReady) && sel_ok && (credit_q >= sel_price)) begin
          state_d    = StDispense;
          credit_d   = credit_q - sel_price;
          dispense_d = sel_onehot;
          cnt_d      = CntInit;
          rej_d      = coin_any;
        end else begin
          if (sum <= MaxSum) begin
            credit_d = sum[CREDIT_W-1:0];
          end else begin
            rej_d = coin_any;
          end
          if (credit_d == '0) begin
            state_d = StIdle;
          end else if (credit_d < min_price) begin
            state_d = StCollect;
          end else begin
            state_d = StReady;
          end
        end
      end
      StDispense: begin
        rej_d = coin_any;
        if (cnt_q == '0) begin
          dispense_d = '0;
          state_d    = (credit_q != '0) ? StChange : StIdle;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StChange: begin
        rej_d = coin_any;
        if (credit_q != '0) begin
          credit_d = credit_q - CREDIT_W'(1);
          change_d = 1'b1;
        end
        if (credit_q <= CREDIT_W'(1)) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d    = StIdle;
        dispense_d = '0;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      credit_q   <= '0;
      dispense_q <= '0;
      change_q   <= 1'b0;
      rej_q      <= 1'b0;
      cnt_q      <= '0;
    end else begin
      state_q    <= state_d;
      credit_q   <= credit_d;
      dispense_q <= dispense_d;
      change_q   <= change_d;
      rej_q      <= rej_d;
      cnt_q      <= cnt_d;
    end
  end

  assign vend.dispense  = dispense_q;
  assign vend.change_05 = change_q;
  assign vend.coin_rej  = rej_q;
  assign vend.credit    = credit_q;
  assign vend.state     = state_q;
  assign vend.busy      = (state_q == StDispense) || (state_q == StChange);

endmodule
